// File: rtl/simon_sw_cond.sv
// +--------------------------------------------------------------------------+
// | Module   : simon_sw_cond                                                 |
// | Purpose  : Switch conditioning for the Simon game. Synchronizes the raw  |
// |            game-play switches, debounces single-switch presses and       |
// |            releases, flags multi-switch chords, and compares the held    |
// |            switch against the colour Simon expects.                      |
// | Macro    : SW_SYNC2_EN - defined: two-flop synchronizer (SYNC=2);        |
// |            undefined: single-flop synchronizer (SYNC=1).                 |
// | Ports    : clk          in   rising-edge clock                            |
// |            rst          in   asynchronous active-low reset                |
// |            sw[3:0]      in   raw switches, bit i = colour i               |
// |            enab         in   conditioning enable (user's turn)            |
// |            expected[1:0] in  colour index expected for this step         |
// |            anySwitch    out  a single debounced switch is held           |
// |            switchMatch  out  held switch index equals expected           |
// |            swIdx[1:0]   out  index of the last accepted press            |
// |            pressPulse   out  one-cycle strobe on accepted press          |
// |            releasePulse out  one-cycle strobe on accepted release        |
// |            relMatch     out  released index equalled expected            |
// |            multi        out  two or more synchronized switches high      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module simon_sw_cond #(
  parameter int DEB_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       enab,
  input  logic [1:0] expected,
  output logic       anySwitch,
  output logic       switchMatch,
  output logic [1:0] swIdx,
  output logic       pressPulse,
  output logic       releasePulse,
  output logic       relMatch,
  output logic       multi
);

`ifdef SW_SYNC2_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  localparam logic [3:0] DEB_C = DEB_CYCLES[3:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEB_P = 2'd1,
    HELD  = 2'd2,
    DEB_R = 2'd3
  } state_t;

  // Synchronizer chain; stage SYNC-1 is the only copy of sw used downstream.
  logic [3:0] sync_q [SYNC];
  logic [3:0] sw_s;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] pat_q, pat_d;
  logic [1:0] idx_q, idx_d;       // index of the pattern being debounced
  logic [1:0] swIdx_q, swIdx_d;   // index published only on accepted press
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       relMatch_q, relMatch_d;
  logic       any_q, any_d;
  logic       match_q, match_d;
  logic       multi_q;

  logic       is_single;
  logic       is_multi;
  logic [1:0] enc_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= 4'd0;
    end else begin
      sync_q[0] <= sw;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_s = sync_q[SYNC-1];

  // x & (x-1) clears the lowest set bit: zero result means at most one bit set.
  assign is_single = (sw_s != 4'd0) && ((sw_s & (sw_s - 4'd1)) == 4'd0);
  assign is_multi  = (sw_s != 4'd0) && !is_single;

  always_comb begin
    enc_idx = 2'd0;
    case (sw_s)
      4'b0001: enc_idx = 2'd0;
      4'b0010: enc_idx = 2'd1;
      4'b0100: enc_idx = 2'd2;
      4'b1000: enc_idx = 2'd3;
      default: enc_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    idx_d      = idx_q;
    swIdx_d    = swIdx_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    relMatch_d = 1'b0;

    if (!enab) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            state_d = DEB_P;
            pat_d   = sw_s;
            idx_d   = enc_idx;
            cnt_d   = 4'd1;
          end
        end
        DEB_P: begin
          if (sw_s == pat_q) begin
            if (cnt_q >= DEB_C) begin
              state_d = HELD;
              press_d = 1'b1;
              swIdx_d = idx_q;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = (cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HELD: begin
          if (sw_s != pat_q) begin
            state_d = DEB_R;
            cnt_d   = 4'd1;
          end
        end
        DEB_R: begin
          if (sw_s == pat_q) begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end else if (cnt_q >= DEB_C) begin
            state_d    = IDLE;
            rel_d      = 1'b1;
            relMatch_d = (idx_q == expected);
            cnt_d      = 4'd0;
          end else begin
            cnt_d = (cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // Outputs are derived from the next state so they line up with the
    // pulses: asserted through DEB_R, dropped in the releasePulse cycle.
    any_d   = (state_d == HELD) || (state_d == DEB_R);
    match_d = any_d && (swIdx_d == expected);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pat_q      <= 4'd0;
      idx_q      <= 2'd0;
      swIdx_q    <= 2'd0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      relMatch_q <= 1'b0;
      any_q      <= 1'b0;
      match_q    <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      idx_q      <= idx_d;
      swIdx_q    <= swIdx_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      relMatch_q <= relMatch_d;
      any_q      <= any_d;
      match_q    <= match_d;
      multi_q    <= is_multi;
    end
  end

  assign anySwitch    = any_q;
  assign switchMatch  = match_q;
  assign swIdx        = swIdx_q;
  assign pressPulse   = press_q;
  assign releasePulse = rel_q;
  assign relMatch     = relMatch_q;
  assign multi        = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_sw_cond.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_simon_sw_cond                                              |
// | Purpose  : Directed scoreboard bench for simon_sw_cond. The stimulus     |
// |            thread queues each expected press/release event with its     |
// |            hand-derived cycle; a monitor pops and checks on every pulse. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_simon_sw_cond;

`ifdef SW_SYNC2_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif
  localparam int DEB = 2;
  // sw driven before edge e => pulse visible after edge e + SYNC + DEB.
  localparam int LAT = SYNC + DEB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       enab = 1'b0;
  logic [1:0] expected = 2'd0;
  logic       anySwitch, switchMatch, pressPulse, releasePulse, relMatch, multi;
  logic [1:0] swIdx;

  simon_sw_cond #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .enab         (enab),
    .expected     (expected),
    .anySwitch    (anySwitch),
    .switchMatch  (switchMatch),
    .swIdx        (swIdx),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .relMatch     (relMatch),
    .multi        (multi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_rel;
    int         at;
    logic [1:0] idx;
    bit         match;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event for sw/rst change driven at this negedge.
  task automatic push_ev(input bit rel, input logic [1:0] idx, input bit m);
    ev_t e;
    e.is_rel = rel;
    e.at     = cyc + 1 + LAT;
    e.idx    = idx;
    e.match  = m;
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (pressPulse && releasePulse) begin
        checks++;
        errors++;
        $display("FAIL pulse_overlap: press=1 release=1 want at most one (cycle %0d)", cyc);
      end else if (pressPulse || releasePulse) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: press=%0b release=%0b want none (cycle %0d)",
                   pressPulse, releasePulse, cyc);
        end else begin
          e = q.pop_front();
          chk("pulse_kind_is_release", 32'(releasePulse), 32'(e.is_rel));
          chk("pulse_cycle", 32'(cyc), 32'(e.at));
          if (!e.is_rel) begin
            chk("press_swIdx", 32'(swIdx), 32'(e.idx));
            chk("press_anySwitch", 32'(anySwitch), 32'd1);
            chk("press_switchMatch", 32'(switchMatch), 32'(e.match));
          end else begin
            chk("release_relMatch", 32'(relMatch), 32'(e.match));
            chk("release_anySwitch", 32'(anySwitch), 32'd0);
            chk("release_switchMatch", 32'(switchMatch), 32'd0);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    ticks(2);
    chk("reset_anySwitch", 32'(anySwitch), 32'd0);
    chk("reset_swIdx", 32'(swIdx), 32'd0);
    chk("reset_pressPulse", 32'(pressPulse), 32'd0);
    chk("reset_multi", 32'(multi), 32'd0);
    rst = 1'b1;
    enab = 1'b1;
    expected = 2'd2;
    ticks(2);

    // Clean press of colour 2 matching expected
    sw = 4'b0100;
    push_ev(1'b0, 2'd2, 1'b1);
    ticks(LAT + 3);
    chk("held_anySwitch", 32'(anySwitch), 32'd1);
    chk("held_swIdx", 32'(swIdx), 32'd2);
    chk("held_switchMatch", 32'(switchMatch), 32'd1);
    chk("held_multi", 32'(multi), 32'd0);

    // One-cycle zero glitch while held: no release
    sw = 4'b0000;
    ticks(1);
    sw = 4'b0100;
    ticks(LAT + 3);
    chk("glitch_held_anySwitch", 32'(anySwitch), 32'd1);

    // Real release, relMatch=1
    sw = 4'b0000;
    push_ev(1'b1, 2'd2, 1'b1);
    ticks(LAT + 3);
    chk("released_anySwitch", 32'(anySwitch), 32'd0);
    chk("released_switchMatch", 32'(switchMatch), 32'd0);
    chk("released_swIdx_kept", 32'(swIdx), 32'd2);

    // One-cycle 0001 glitch: enters DEB_P, aborts, no press, swIdx kept
    sw = 4'b0001;
    ticks(1);
    sw = 4'b0000;
    ticks(LAT + 3);
    chk("press_glitch_swIdx", 32'(swIdx), 32'd2);
    chk("press_glitch_anySwitch", 32'(anySwitch), 32'd0);

    // Chord: multi, no press; then single 0001 accepted (no match vs 2)
    sw = 4'b0011;
    ticks(SYNC + 2);
    chk("chord_multi", 32'(multi), 32'd1);
    chk("chord_anySwitch", 32'(anySwitch), 32'd0);
    sw = 4'b0001;
    push_ev(1'b0, 2'd0, 1'b0);
    ticks(LAT + 3);
    chk("after_chord_multi", 32'(multi), 32'd0);
    chk("after_chord_anySwitch", 32'(anySwitch), 32'd1);
    chk("after_chord_swIdx", 32'(swIdx), 32'd0);
    sw = 4'b0000;
    push_ev(1'b1, 2'd0, 1'b0);
    ticks(LAT + 3);

    // Colour 3 held with expected=1; switchMatch tracks expected every cycle
    expected = 2'd1;
    sw = 4'b1000;
    push_ev(1'b0, 2'd3, 1'b0);
    ticks(LAT + 3);
    chk("mismatch_switchMatch", 32'(switchMatch), 32'd0);
    chk("mismatch_swIdx", 32'(swIdx), 32'd3);
    expected = 2'd3;
    ticks(2);
    chk("track_switchMatch", 32'(switchMatch), 32'd1);
    expected = 2'd1;
    ticks(1);
    sw = 4'b0000;
    push_ev(1'b1, 2'd3, 1'b0);
    ticks(LAT + 3);

    // Enable dropped while held: outputs cleared, swIdx retained, no release
    sw = 4'b0010;
    push_ev(1'b0, 2'd1, 1'b1);
    ticks(LAT + 3);
    chk("pre_disable_switchMatch", 32'(switchMatch), 32'd1);
    enab = 1'b0;
    ticks(1);
    chk("disable_anySwitch", 32'(anySwitch), 32'd0);
    chk("disable_switchMatch", 32'(switchMatch), 32'd0);
    chk("disable_swIdx", 32'(swIdx), 32'd1);
    sw = 4'b0000;
    ticks(LAT + 3);
    enab = 1'b1;
    ticks(2);

    // Asynchronous reset while debouncing a press
    expected = 2'd2;
    sw = 4'b0100;
    ticks(SYNC + 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_swIdx", 32'(swIdx), 32'd0);
    chk("async_rst_anySwitch", 32'(anySwitch), 32'd0);
    chk("async_rst_pressPulse", 32'(pressPulse), 32'd0);
    chk("async_rst_multi", 32'(multi), 32'd0);
    ticks(2);
    rst = 1'b1;
    push_ev(1'b0, 2'd2, 1'b1);
    ticks(LAT + 3);
    sw = 4'b0000;
    push_ev(1'b1, 2'd2, 1'b1);
    ticks(LAT + 4);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
